// File: rtl/apb_uart_ctrl.sv
// APB master that configures a 16750-style UART and then moves bytes between
// a TX valid/ready stream, the UART FIFOs and a one-entry RX holding register.
module apb_uart_ctrl #(
    parameter type apb_req_t = logic,
    parameter type apb_rsp_t = logic
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] divisor_i,
    output apb_req_t    apb_req_o,
    input  apb_rsp_t    apb_rsp_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        init_done_o,
    output logic        err_o
);

    // Field order must match the apb_req_t/apb_rsp_t structs supplied by the parent.
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } req_bits_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } rsp_bits_t;

    typedef enum logic [2:0] {INIT, IDLE, POLL, RXRD, TXWR} state_t;

    localparam logic [4:0] ADDR_RBR = 5'h00;
    localparam logic [4:0] ADDR_THR = 5'h00;
    localparam logic [4:0] ADDR_DLL = 5'h00;
    localparam logic [4:0] ADDR_IER = 5'h04;
    localparam logic [4:0] ADDR_DLM = 5'h04;
    localparam logic [4:0] ADDR_FCR = 5'h08;
    localparam logic [4:0] ADDR_LCR = 5'h0C;
    localparam logic [4:0] ADDR_MCR = 5'h10;
    localparam logic [4:0] ADDR_LSR = 5'h14;
    localparam logic [2:0] INIT_LAST = 3'd6;

    state_t     state;
    logic       psel_q;
    logic       penable_q;
    logic [4:0] paddr_q;
    logic       pwrite_q;
    logic [7:0] wdata_q;
    logic [2:0] init_idx;
    logic [15:0] divisor_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       init_done_q;
    logic       err_q;

    rsp_bits_t  rsp;
    req_bits_t  req;
    logic       xfer_done;
    logic       unused_prdata;

    // Returns {paddr, pwdata} for each step of the configuration sequence.
    function automatic logic [12:0] init_step(input logic [2:0] idx, input logic [15:0] div);
        logic [12:0] step;
        case (idx)
            3'd0:    step = {ADDR_LCR, 8'h83};
            3'd1:    step = {ADDR_DLL, div[7:0]};
            3'd2:    step = {ADDR_DLM, div[15:8]};
            3'd3:    step = {ADDR_LCR, 8'h03};
            3'd4:    step = {ADDR_FCR, 8'h07};
            3'd5:    step = {ADDR_IER, 8'h00};
            default: step = {ADDR_MCR, 8'h00};
        endcase
        return step;
    endfunction

    assign rsp           = rsp_bits_t'(apb_rsp_i);
    assign unused_prdata = ^rsp.prdata[31:8];
    assign xfer_done     = psel_q & penable_q & rsp.pready;

    always_comb begin
        req         = '0;
        req.paddr   = {27'b0, paddr_q};
        req.pprot   = 3'b000;
        req.psel    = psel_q;
        req.penable = penable_q;
        req.pwrite  = pwrite_q;
        req.pwdata  = {24'b0, wdata_q};
        req.pstrb   = 4'hF;
    end

    assign apb_req_o   = apb_req_t'(req);
    assign tx_ready_o  = (state == TXWR) & xfer_done;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= INIT;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= ADDR_LCR;
            pwrite_q    <= 1'b1;
            wdata_q     <= 8'h00;
            init_idx    <= 3'd0;
            divisor_q   <= 16'h0000;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (psel_q && !penable_q)
                penable_q <= 1'b1;
            if (xfer_done && rsp.pslverr)
                err_q <= 1'b1;
            if (rx_valid_q && rx_ready_i)
                rx_valid_q <= 1'b0;

            // Each branch either chains straight into the next SETUP or drops psel.
            case (state)
                INIT: begin
                    if (!psel_q) begin
                        divisor_q            <= divisor_i;
                        {paddr_q, wdata_q}   <= init_step(3'd0, divisor_i);
                        pwrite_q             <= 1'b1;
                        psel_q               <= 1'b1;
                        penable_q            <= 1'b0;
                    end else if (xfer_done) begin
                        if (init_idx == INIT_LAST) begin
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            init_done_q <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            init_idx           <= init_idx + 3'd1;
                            {paddr_q, wdata_q} <= init_step(init_idx + 3'd1, divisor_q);
                            penable_q          <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    if (tx_valid_i || !rx_valid_q) begin
                        paddr_q   <= ADDR_LSR;
                        pwrite_q  <= 1'b0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state     <= POLL;
                    end
                end
                POLL: begin
                    if (xfer_done) begin
                        if (!rsp.pslverr && rsp.prdata[0] && !rx_valid_q) begin
                            paddr_q   <= ADDR_RBR;
                            pwrite_q  <= 1'b0;
                            penable_q <= 1'b0;
                            state     <= RXRD;
                        end else if (!rsp.pslverr && rsp.prdata[5] && tx_valid_i) begin
                            paddr_q   <= ADDR_THR;
                            pwrite_q  <= 1'b1;
                            wdata_q   <= tx_data_i;
                            penable_q <= 1'b0;
                            state     <= TXWR;
                        end else begin
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                RXRD: begin
                    if (xfer_done) begin
                        if (!rsp.pslverr) begin
                            rx_data_q  <= rsp.prdata[7:0];
                            rx_valid_q <= 1'b1;
                        end
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                TXWR: begin
                    if (xfer_done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state     <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Directed bench for apb_uart_ctrl with a behavioural APB UART slave that
// logs every completed transfer and can insert wait states or errors on THR writes.
module tb_apb_uart_ctrl;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_rsp_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] divisor;
    apb_req_t    req;
    apb_rsp_t    rsp;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        init_done;
    logic        err;

    logic [7:0]  lsr_val;
    logic [7:0]  rbr_val;
    int          thr_wait;
    logic        thr_err;
    int          acc_cnt = 0;
    logic        is_thr;

    xfer_t       log_q[$];
    int          early_cnt = 0;
    int          tx_ready_cnt = 0;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    apb_uart_ctrl #(
        .apb_req_t(apb_req_t),
        .apb_rsp_t(apb_rsp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .divisor_i  (divisor),
        .apb_req_o  (req),
        .apb_rsp_i  (rsp),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .init_done_o(init_done),
        .err_o      (err)
    );

    assign is_thr = req.pwrite && (req.paddr == 32'h0);

    // Slave: junk in prdata[31:8] so only the low byte may reach rx_data.
    always_comb begin
        rsp         = '0;
        rsp.pready  = req.psel && req.penable && (acc_cnt >= (is_thr ? thr_wait : 0));
        rsp.pslverr = rsp.pready && is_thr && thr_err;
        if (!req.pwrite && req.paddr == 32'h14)
            rsp.prdata = {24'hC0FFEE, lsr_val};
        else if (!req.pwrite && req.paddr == 32'h00)
            rsp.prdata = {24'hC0FFEE, rbr_val};
    end

    always @(posedge clk) begin
        if (req.psel && req.penable && !rsp.pready)
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
        if (rst_n && req.psel && req.penable && rsp.pready)
            log_q.push_back('{req.pwrite, req.paddr, req.pwrite ? req.pwdata : rsp.prdata,
                              req.pstrb, req.pprot});
        if (rst_n === 1'b1 && !init_done && (tx_ready || rx_valid))
            early_cnt <= early_cnt + 1;
        if (tx_ready)
            tx_ready_cnt <= tx_ready_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits for psel low (controller in IDLE) before presenting the next scenario.
    task automatic applyStimulus(input logic [7:0] lsr, input logic [7:0] rbr,
                                 input logic [7:0] txd, input logic txv);
        int n = 0;
        while (req.psel !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20)
            checkOutput("idle_wait_timeout", 32'd0, 32'd1);
        lsr_val  = lsr;
        rbr_val  = rbr;
        tx_data  = txd;
        tx_valid = txv;
    endtask

    task automatic waitInitDone(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        logic [31:0] exp_addr [7];
        logic [31:0] exp_data [7];
        logic [31:0] exp_seq  [4];
        int n;
        int mark;
        int reads;
        int writes;
        int ready_base;
        int rdy_cnt;
        int acc;
        int setups;
        int bad;
        logic drop;

        exp_addr = '{32'h0C, 32'h00, 32'h04, 32'h0C, 32'h08, 32'h04, 32'h10};
        exp_data = '{32'h83, 32'hB2, 32'h01, 32'h03, 32'h07, 32'h00, 32'h00};
        exp_seq  = '{32'h014, 32'h000, 32'h014, 32'h100};

        rst_n    = 1'b0;
        divisor  = 16'h01B2;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        lsr_val  = 8'h00;
        rbr_val  = 8'h00;
        thr_wait = 0;
        thr_err  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_psel", {31'b0, req.psel}, 32'd0);
        checkOutput("rst_penable", {31'b0, req.penable}, 32'd0);
        checkOutput("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
        checkOutput("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("rst_rx_data", {24'b0, rx_data}, 32'd0);
        checkOutput("rst_init_done", {31'b0, init_done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);

        $display("[TB] init sequence, divisor 0x01B2");
        rst_n = 1'b1;
        waitInitDone(n);
        checkOutput("init_latency", n, 32'd15);
        checkOutput("init_count", log_q.size(), 32'd7);
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            checkOutput($sformatf("init%0d_w", i), {31'b0, log_q[i].w}, 32'd1);
            checkOutput($sformatf("init%0d_addr", i), log_q[i].addr, exp_addr[i]);
            checkOutput($sformatf("init%0d_data", i), log_q[i].data, exp_data[i]);
        end
        if (log_q.size() > 0) begin
            checkOutput("init_pstrb", {28'b0, log_q[0].strb}, 32'hF);
            checkOutput("init_pprot", {29'b0, log_q[0].prot}, 32'h0);
        end

        $display("[TB] idle polling with LSR=0x00");
        mark       = log_q.size();
        ready_base = tx_ready_cnt;
        repeat (20) @(negedge clk);
        reads  = 0;
        writes = 0;
        for (int i = mark; i < log_q.size(); i++) begin
            if (log_q[i].w) writes++;
            else if (log_q[i].addr == 32'h14) reads++;
        end
        checkOutput("poll_lsr_reads", reads, 32'd6);
        checkOutput("poll_no_writes", writes, 32'd0);
        checkOutput("poll_no_tx_ready", tx_ready_cnt - ready_base, 32'd0);
        checkOutput("init_done_hold", {31'b0, init_done}, 32'd1);

        $display("[TB] TX byte 0x5A, LSR=0x60");
        applyStimulus(8'h60, 8'h00, 8'h5A, 1'b1);
        @(negedge clk);
        checkOutput("tx_t1_lsr_setup", {21'b0, req.psel, req.penable, req.pwrite, req.paddr[7:0]}, 32'h414);
        @(negedge clk);
        checkOutput("tx_t2_lsr_access", {21'b0, req.psel, req.penable, req.pwrite, req.paddr[7:0]}, 32'h614);
        @(negedge clk);
        checkOutput("tx_t3_thr_setup", {21'b0, req.psel, req.penable, req.pwrite, req.paddr[7:0]}, 32'h500);
        checkOutput("tx_t3_pwdata", req.pwdata, 32'h5A);
        checkOutput("tx_t3_ready_low", {31'b0, tx_ready}, 32'd0);
        @(negedge clk);
        checkOutput("tx_t4_thr_access", {21'b0, req.psel, req.penable, req.pwrite, req.paddr[7:0]}, 32'h700);
        checkOutput("tx_t4_ready", {31'b0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("tx_t5_ready_low", {31'b0, tx_ready}, 32'd0);
        checkOutput("tx_t5_psel_low", {31'b0, req.psel}, 32'd0);
        checkOutput("tx_thr_logged", {23'b0, log_q[log_q.size()-1].w, log_q[log_q.size()-1].addr[7:0]}, 32'h100);
        checkOutput("tx_thr_data", log_q[log_q.size()-1].data, 32'h5A);

        $display("[TB] RX and TX both eligible, LSR=0x61");
        applyStimulus(8'h61, 8'hA7, 8'h3C, 1'b1);
        mark = log_q.size();
        n = 0;
        while (!tx_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("both_tx_ready", {31'b0, tx_ready}, 32'd1);
        checkOutput("both_rx_valid", {31'b0, rx_valid}, 32'd1);
        checkOutput("both_rx_data", {24'b0, rx_data}, 32'hA7);
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("both_xfer_count", log_q.size() - mark, 32'd4);
        for (int i = 0; i < 4 && (mark + i) < log_q.size(); i++)
            checkOutput($sformatf("both_seq%0d", i),
                        {23'b0, log_q[mark+i].w, log_q[mark+i].addr[7:0]}, exp_seq[i]);
        if (log_q.size() >= mark + 4)
            checkOutput("both_thr_data", log_q[mark+3].data, 32'h3C);
        repeat (5) @(negedge clk);
        checkOutput("rx_hold_valid", {31'b0, rx_valid}, 32'd1);
        checkOutput("rx_hold_data", {24'b0, rx_data}, 32'hA7);
        checkOutput("rx_hold_no_poll", log_q.size() - mark, 32'd4);
        lsr_val  = 8'h00;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checkOutput("rx_consumed", {31'b0, rx_valid}, 32'd0);

        $display("[TB] THR write with 3 wait states and pslverr");
        checkOutput("err_clear_before", {31'b0, err}, 32'd0);
        thr_wait = 3;
        thr_err  = 1'b1;
        applyStimulus(8'h60, 8'h00, 8'hC3, 1'b1);
        rdy_cnt = 0;
        acc     = 0;
        setups  = 0;
        bad     = 0;
        drop    = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (drop) tx_valid = 1'b0;
            drop = tx_ready;
            if (tx_ready) rdy_cnt++;
            if (req.psel && req.pwrite && !req.penable) setups++;
            if (req.psel && req.pwrite && req.penable) begin
                acc++;
                if (req.pwdata != 32'hC3 || req.paddr != 32'h0) bad++;
            end
        end
        checkOutput("wait_ready_once", rdy_cnt, 32'd1);
        checkOutput("wait_access_cycles", acc, 32'd4);
        checkOutput("wait_setups", setups, 32'd1);
        checkOutput("wait_stable", bad, 32'd0);
        checkOutput("wait_err_set", {31'b0, err}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("wait_err_sticky", {31'b0, err}, 32'd1);

        $display("[TB] reset during THR access");
        thr_err  = 1'b0;
        thr_wait = 5;
        divisor  = 16'h1234;
        applyStimulus(8'h60, 8'h00, 8'h99, 1'b1);
        n = 0;
        while (!(req.psel && req.penable && req.pwrite) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_found_access", {31'b0, req.psel && req.penable && req.pwrite}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_psel", {31'b0, req.psel}, 32'd0);
        checkOutput("abort_penable", {31'b0, req.penable}, 32'd0);
        checkOutput("abort_tx_ready", {31'b0, tx_ready}, 32'd0);
        checkOutput("abort_rx_valid", {31'b0, rx_valid}, 32'd0);
        checkOutput("abort_rx_data", {24'b0, rx_data}, 32'd0);
        checkOutput("abort_init_done", {31'b0, init_done}, 32'd0);
        checkOutput("abort_err", {31'b0, err}, 32'd0);
        tx_valid = 1'b0;
        thr_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mark  = log_q.size();
        waitInitDone(n);
        checkOutput("reinit_done", {31'b0, init_done}, 32'd1);
        checkOutput("reinit_count", log_q.size() - mark, 32'd7);
        if (log_q.size() >= mark + 3) begin
            checkOutput("reinit_lcr", {23'b0, log_q[mark].w, log_q[mark].addr[7:0]}, 32'h10C);
            checkOutput("reinit_lcr_data", log_q[mark].data, 32'h83);
            checkOutput("reinit_dll", log_q[mark+1].data, 32'h34);
            checkOutput("reinit_dlm", log_q[mark+2].data, 32'h12);
        end
        checkOutput("no_early_handshake", early_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_ctrl.md
APB_UART_CTRL -- requirements
Module: apb_uart_ctrl

Interface
REQ-001 SHALL have parameter apb_req_t, default logic, meaning APB request struct (paddr, pprot, psel, penable, pwrite, pwdata, pstrb).
REQ-002 SHALL have parameter apb_rsp_t, default logic, meaning APB response struct (pready, prdata, pslverr).
REQ-003 SHALL have ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, synchronous, active-low.
- divisor_i  in  16  baud divisor, sampled at init start.
- apb_req_o  out  apb_req_t  APB master request to the 16750 UART.
- apb_rsp_i  in  apb_rsp_t  APB response from the UART.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  TX byte valid.
- tx_ready_o  out  1  TX byte accepted, i.e. THR write completed.
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  RX byte valid.
- rx_ready_i  in  1  RX byte consumed.
- init_done_o  out  1  UART configured.
- err_o  out  1  sticky pslverr seen.

Function
REQ-010 SHALL address UART register k at paddr = k<<2: RBR/THR/DLL=0, IER/DLM=1, FCR=2, LCR=3, MCR=4, LSR=5.
REQ-011 SHALL drive pprot=0 and pstrb=4'hF, and pwdata[31:8]=0 on every write.
REQ-012 SHALL run each transfer as SETUP (psel=1, penable=0, one cycle), then ACCESS (psel=1, penable=1) held until pready=1, then psel=0 unless the next SETUP follows immediately.
REQ-013 SHALL hold paddr, pwrite and pwdata stable from SETUP through the completing ACCESS cycle.
REQ-014 SHALL use states INIT, IDLE, POLL, RXRD and TXWR.
REQ-015 In INIT, SHALL write in order LCR=0x83, DLL=divisor[7:0], DLM=divisor[15:8], LCR=0x03, FCR=0x07, IER=0x00, MCR=0x00.
REQ-016 SHALL set init_done_o=1 in the cycle after the MCR write completes, then enter IDLE; init_done_o SHALL stay 1 until reset.
REQ-017 SHALL keep tx_ready_o=0 and rx_valid_o=0 while init_done_o=0.
REQ-018 In IDLE, SHALL go to POLL (LSR read) when tx_valid_i=1 or the RX holding register is empty; otherwise SHALL stay in IDLE with psel=0.
REQ-019 On POLL completion: if LSR[0]=1 and the RX holding register is empty, SHALL go to RXRD; else if LSR[5]=1 and tx_valid_i=1, SHALL go to TXWR; else SHALL go to IDLE.
REQ-020 When both RX and TX are eligible, SHALL serve RX first; TX SHALL then wait for a fresh LSR poll.
REQ-021 TXWR SHALL latch tx_data_i at SETUP, write it to THR, and assert tx_ready_o for exactly the completing ACCESS cycle.
REQ-022 RXRD SHALL load prdata[7:0] into the 1-entry RX holding register on completion and set rx_valid_o=1 the next cycle.
REQ-023 rx_valid_o and rx_data_o SHALL stay stable until rx_valid_o & rx_ready_i, and rx_valid_o SHALL clear the following cycle.
REQ-024 With pready=1 in every first ACCESS cycle, tx_valid_i seen in IDLE at cycle t SHALL give LSR SETUP at t+1, LSR ACCESS at t+2, THR SETUP at t+3, and tx_ready_o=1 at t+4.
REQ-025 On pslverr=1 in a completing cycle, SHALL set err_o=1 and treat the transfer as done; an erroring RBR read SHALL NOT load the holding register, and an erroring THR write SHALL still assert tx_ready_o.
REQ-026 SHALL support arbitrary wait states (pready=0) in any ACCESS cycle without dropping psel.

Reset
REQ-030 On clk_i edge with rst_ni=0, SHALL set: state=INIT at first write; psel=0, penable=0; tx_ready_o=0, rx_valid_o=0, rx_data_o=0, init_done_o=0, err_o=0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer (psel=0 next cycle) and restart the full INIT sequence after release.

Verification
REQ-040 divisor_i=0x01B2, zero-wait slave -> writes 0x83@0x0C, 0xB2@0x00, 0x01@0x04, 0x03@0x0C, 0x07@0x08, 0x00@0x04, 0x00@0x10, then init_done_o=1.
REQ-041 tx_data_i=0x5A, LSR=0x60 -> LSR read then THR write of 0x5A@0x00, with tx_ready_o high at t+4.
REQ-042 LSR=0x61, RBR=0xA7, tx_valid_i=1 -> RBR read first, rx_data_o=0xA7, rx_valid_o held while rx_ready_i=0, then re-poll before THR write.
REQ-043 LSR=0x00 repeated -> continuous LSR polling, no THR write, tx_ready_o=0.
REQ-044 pready=0 for 3 cycles on THR write, with pslverr=1 on completion -> signals stable throughout, tx_ready_o=1 once, err_o=1 sticky.
REQ-045 rst_ni low during THR ACCESS -> psel=0 next cycle, all outputs at reset values, INIT restarts at LCR=0x83.
